// File: rtl/rf_wb_arb.sv
// rf_wb_arb: round-robin arbiter for the single register-file write port.
// Several writeback sources (ALU, load unit, mul/div) each present one request.
// Each cycle at most one request is granted. The granted write reaches the
// register file one cycle later as a single-cycle write.
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   req_valid     - per-requester write request
//   req_ready     - one-hot grant (combinational from req_valid, ptr, rst)
//   req_addr/data - packed per-requester destination register and data
//   write         - registered register-file write enable (never for x0)
//   rd_addr       - registered register-file write address
//   resdata       - registered register-file write data
//   wr_src        - registered index of the source on the port
//   conflict_cnt  - saturating count of cycles with >=2 valid requests
module rf_wb_arb #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned SW   = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 write,
  output logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        resdata,
  output logic [SW-1:0]        wr_src,
  output logic [CNTW-1:0]      conflict_cnt
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_ptr;
  logic            r_write;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic [SW-1:0]   r_src;
  logic [CNTW-1:0] r_cnt;

  logic            w_found;
  logic [PW-1:0]   w_gnt;
  logic [PW:0]     w_sum;
  logic [PW:0]     w_idx;
  logic [AW-1:0]   w_gaddr;
  logic [DW-1:0]   w_gdata;
  logic [PW-1:0]   w_nptr;
  logic            w_xfer;
  logic            w_multi;

  // Round-robin search starting at r_ptr, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      w_idx = (w_sum >= (PW+1)'(NREQ)) ? (w_sum - (PW+1)'(NREQ)) : w_sum;
      if (!w_found && req_valid[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[PW-1:0];
      end
    end
  end

  // Payload mux for the granted requester.
  always_comb begin
    w_gaddr = '0;
    w_gdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt == PW'(k)) begin
        w_gaddr = req_addr[k*AW +: AW];
        w_gdata = req_data[k*DW +: DW];
      end
    end
  end

  assign w_xfer  = w_found && !rst;
  assign w_nptr  = ({1'b0, w_gnt} == (PW+1)'(NREQ - 1)) ? '0 : PW'(w_gnt + 1'b1);
  // Clearing the lowest set bit leaves something iff two or more are set.
  assign w_multi = |(req_valid & (req_valid - NREQ'(1)));

  assign req_ready = w_xfer ? (NREQ'(1) << w_gnt) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_src   <= '0;
      r_cnt   <= '0;
    end else begin
      // Writes to x0 are accepted but suppressed at the port.
      r_write <= w_xfer && (w_gaddr != '0);
      if (w_xfer) begin
        r_addr <= w_gaddr;
        r_data <= w_gdata;
        r_src  <= SW'(w_gnt);
        r_ptr  <= w_nptr;
      end
      if (w_multi && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign write        = r_write;
  assign rd_addr      = r_addr;
  assign resdata      = r_data;
  assign wr_src       = r_src;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb: directed scenarios followed by random traffic, all
// checked against a transaction-level round-robin model.
module tb_rf_wb_arb;

  localparam int unsigned NREQ = 3;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned SW   = 2;
  localparam int unsigned CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic                 write;
  logic [AW-1:0]        rd_addr;
  logic [DW-1:0]        resdata;
  logic [SW-1:0]        wr_src;
  logic [CNTW-1:0]      conflict_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_ptr;
  int         m_cnt;
  logic       m_write;
  logic [4:0] m_addr;
  logic [31:0] m_data;
  int         m_src;

  always #5 clk = ~clk;

  rf_wb_arb #(.NREQ(NREQ), .DW(DW), .AW(AW), .SW(SW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .write(write), .rd_addr(rd_addr), .resdata(resdata),
    .wr_src(wr_src), .conflict_cnt(conflict_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // One clock cycle: check grant, advance model, check registered outputs.
  task automatic step(output int g);
    int nv;
    logic [2:0] er;
    #1;
    g  = -1;
    nv = 0;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    er = (g >= 0) ? 3'(1 << g) : 3'b000;
    check("ready", 64'(req_ready), 64'(er));
    for (int k = 0; k < NREQ; k++) nv += int'(req_valid[k]);
    if (rst) begin
      m_ptr = 0; m_cnt = 0; m_write = 1'b0; m_addr = '0; m_data = '0; m_src = 0;
    end else begin
      if (nv >= 2 && m_cnt < CMAX) m_cnt++;
      if (g >= 0) begin
        m_addr  = req_addr[g*AW +: AW];
        m_data  = req_data[g*DW +: DW];
        m_write = (m_addr != 5'd0);
        m_src   = g;
        m_ptr   = (g + 1) % NREQ;
      end else begin
        m_write = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("write",   64'(write),        64'(m_write));
    check("rd_addr", 64'(rd_addr),      64'(m_addr));
    check("resdata", 64'(resdata),      64'(m_data));
    check("wr_src",  64'(wr_src),       64'(m_src));
    check("cnt",     64'(conflict_cnt), 64'(m_cnt));
  endtask

  initial begin
    int g;
    m_ptr = 0; m_cnt = 0; m_write = 1'b0; m_addr = '0; m_data = '0; m_src = 0;
    req_addr = '0;
    req_data = '0;

    // Reset with all requesters valid
    rst = 1'b1;
    req_valid = 3'b111;
    step(g);
    step(g);
    check("rst_cnt", 64'(conflict_cnt), 64'd0);
    rst = 1'b0;
    req_valid = '0;
    step(g);

    // Single write from requester 1
    set_req(1, 5'd5, 32'hDEADBEEF);
    step(g);
    check("single_wr", 64'(write), 64'd1);
    check("single_addr", 64'(rd_addr), 64'd5);
    req_valid = '0;
    step(g);
    check("single_idle", 64'(write), 64'd0);

    // Round-robin after a fresh reset
    rst = 1'b1;
    step(g);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), $urandom);
    for (int n = 0; n < 6; n++) begin
      step(g);
      check("rr_grant", 64'(g), 64'(n % 3));
      check("rr_write", 64'(write), 64'd1);
      set_req(g, 5'($urandom_range(1, 31)), $urandom);
    end
    check("rr_cnt", 64'(conflict_cnt), 64'd6);
    req_valid = '0;

    // Register 0 write is accepted but suppressed
    set_req(2, 5'd0, 32'h1234);
    step(g);
    check("x0_write", 64'(write), 64'd0);
    check("x0_src", 64'(wr_src), 64'd2);
    req_valid = '0;
    set_req(0, 5'd3, 32'h55);
    set_req(2, 5'd4, 32'h66);
    step(g);
    check("x0_next", 64'(g), 64'd0);
    req_valid = '0;

    // Counter saturation
    for (int n = 0; n < 20; n++) begin
      set_req(0, 5'($urandom_range(1, 31)), $urandom);
      set_req(1, 5'($urandom_range(1, 31)), $urandom);
      step(g);
    end
    check("sat", 64'(conflict_cnt), 64'(CMAX));
    req_valid = '0;

    // Reset mid-stream
    set_req(1, 5'd7, 32'hCAFE0007);
    step(g);
    check("mid_wr", 64'(write), 64'd1);
    check("mid_addr", 64'(rd_addr), 64'd7);
    req_valid = '0;
    rst = 1'b1;
    step(g);
    check("mid_clr", 64'(write), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 8), $urandom);
    step(g);
    check("mid_first", 64'(g), 64'd0);
    if (g >= 0) req_valid[g] = 1'b0;

    // Random traffic; requests stay stable until accepted
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      step(g);
      if (g >= 0) req_valid[g] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arb.md
Name: rf_wb_arb

Overview:
- Arbitrates the single register-file write port (rd_addr/resdata/write) among multiple writeback sources: ALU, load unit, multiply/divide unit.
- Uses round-robin grant with a valid/ready handshake per requester.
- Drives a registered single-cycle write toward the register file and counts arbitration conflicts for performance monitoring.
- Sits between the execute/memory-stage result producers and the register file.

Parameters:
- NREQ, 3, number of writeback requesters (2..4).
- DW, 32, data word width.
- AW, 5, register address width.
- SW, 2, width of the source-ID output.
- CNTW, 16, width of the conflict counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester write request.
- req_ready  output  NREQ  per-requester grant; transfer occurs when valid & ready.
- req_addr  input  NREQ*AW  destination register; requester i at [i*AW +: AW].
- req_data  input  NREQ*DW  write data; requester i at [i*DW +: DW].
- write  output  1  register-file write enable.
- rd_addr  output  AW  register-file write address.
- resdata  output  DW  register-file write data.
- wr_src  output  SW  index of the requester whose write is currently on the port.
- conflict_cnt  output  CNTW  saturating count of cycles with two or more valid requests.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: write=0, rd_addr=0, resdata=0, wr_src=0, conflict_cnt=0, internal priority pointer ptr=0.
  - While rst=1, req_ready is all zeros and no transfer occurs.
- Grant (combinational from req_valid and ptr):
  - Search requesters starting at ptr, ascending modulo NREQ. The first valid one is granted.
  - req_ready is one-hot at the granted index, or zero when no request is valid.
  - At most one transfer per cycle.
- Pointer update:
  - On a transfer from requester g, ptr <= (g+1) mod NREQ.
  - With no transfer, ptr holds.
- Latency:
  - A transfer in cycle T produces write=1, rd_addr=addr, resdata=data, wr_src=g in cycle T+1 only.
  - Back-to-back transfers give one write per cycle, with no bubble.
- Idle: in a cycle with no transfer, write=0 in the next cycle. rd_addr, resdata and wr_src hold their last values.
- Register 0: a request with addr==0 is accepted normally (ready asserted, ptr advances).
  - Next cycle: write=0, while rd_addr, resdata and wr_src update as usual.
- Requester rules:
  - Once valid is asserted, valid, addr and data stay stable until accepted.
  - Valid is never withdrawn before acceptance. Violations are bench assertion failures.
- Same-destination requests in one cycle: only the granted one writes. The other writes in a later cycle and overwrites. Ordering between sources follows grant order only.
- conflict_cnt:
  - Increments by 1 in each non-reset cycle where popcount(req_valid) >= 2.
  - Saturates at 2^CNTW-1 and never wraps.
- Reset mid-operation:
  - A write already registered before rst is asserted still appears in that cycle.
  - The edge sampling rst=1 clears write, ptr and conflict_cnt.
  - No request is accepted during reset.
  - After reset deassertion, arbitration restarts with requester 0 at highest priority.
- No combinational path from any req_data/req_addr input to any output other than req_ready. req_ready depends only on req_valid, ptr and rst.

Test Plan:
- Reset: rst=1 for 2 cycles with req_valid=3'b111 -> req_ready=0, write=0, rd_addr=0, resdata=0, wr_src=0, conflict_cnt=0 throughout.
- Single write: cycle T, req_valid=3'b010, addr1=5, data1=0xDEADBEEF -> req_ready=3'b010 at T. At T+1: write=1, rd_addr=5, resdata=0xDEADBEEF, wr_src=1. At T+2: write=0.
- Round-robin: after reset, hold all three valid, each re-presenting new data on acceptance -> grants 0,1,2,0,1,2 on consecutive cycles, write=1 every cycle from T+1, conflict_cnt=6 after 6 cycles.
- Register 0: req_valid=3'b100, addr2=0, data2=0x1234 -> req_ready=3'b100, next cycle write=0, wr_src=2. A following request from requester 0 is granted first (ptr=0).
- Saturation (CNTW=4): 20 cycles with req_valid=3'b011 and requesters re-requesting -> conflict_cnt reaches 15 and stays 15.
- Reset mid-stream: transfer at T from requester 1 (addr 7), rst=1 during T+1 -> write=1, rd_addr=7 at T+1. At T+2: write=0, conflict_cnt=0, and the first grant after deassertion goes to requester 0 when all are valid.
